// File: rtl/sound_buffer_pkg.sv
// Shared types for the sound frame bank controller.
// Bank lifecycle and writer modes.
package sound_buffer_pkg;

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    FULL,
    READING
  } bank_state_t;

  typedef enum logic {
    RUN,
    HOLD
  } wr_state_t;

  localparam int BANK_W = $clog2(3);
  localparam int ADDR_W = $clog2(512);

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port frame storage, one clock.
// Registered read port so it maps onto block RAM.
module frame_bank_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1536,
  parameter int AW     = 11
) (
  input  logic              clk_25,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_25) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sound_frame_bank_ctrl.sv
// N-bank frame buffer with ordered full queue
// and claim/release handoff to the reader.
module sound_frame_bank_ctrl
  import sound_buffer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 512,
  parameter int NUM_BANKS = 3,
  parameter int OVERWRITE = 1
) (
  input  logic                         clk_25,
  input  logic                         RST_N,
  input  logic                         s_valid,
  input  logic [DATA_W-1:0]            s_data,
  output logic                         frame_valid,
  output logic [$clog2(NUM_BANKS)-1:0] frame_bank,
  input  logic                         frame_take,
  input  logic                         rd_en,
  input  logic [$clog2(FRAME_LEN)-1:0] rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  input  logic                         frame_release,
  output logic                         ovf_pulse,
  output logic [15:0]                  drop_cnt
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int AW = $clog2(FRAME_LEN);
  localparam int CW = $clog2(NUM_BANKS + 1);
  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

  bank_state_t       bs    [NUM_BANKS];
  bank_state_t       bs_n  [NUM_BANKS];
  logic [BW-1:0]     q     [NUM_BANKS];
  logic [BW-1:0]     q_n   [NUM_BANKS];
  logic [CW-1:0]     qc, qc_n;
  logic [BW-1:0]     wr_bank, wr_bank_n;
  logic [AW-1:0]     wr_ptr, wr_ptr_n;
  wr_state_t         ws, ws_n;
  logic              claimed, claimed_n;
  logic [BW-1:0]     rd_bank, rd_bank_n;
  logic              ovf_n;
  logic              rd_zero;
  logic [BW:0]       sel;
  logic [DATA_W-1:0] ram_q;

  // {found, index}: first FREE bank scanning from+1, from+2, ...
  function automatic logic [BW:0] first_free(
    input bank_state_t   st [NUM_BANKS],
    input logic [BW-1:0] from
  );
    logic [BW:0] r;
    int          idx;
    r = '0;
    for (int k = NUM_BANKS; k >= 1; k--) begin
      idx = (int'(from) + k) % NUM_BANKS;
      if (st[idx] == FREE) r = {1'b1, BW'(idx)};
    end
    return r;
  endfunction

  always_ff @(posedge clk_25 or negedge RST_N) begin
    if (!RST_N) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bs[b] <= FREE;
        q[b]  <= '0;
      end
      qc        <= '0;
      wr_bank   <= '0;
      wr_ptr    <= '0;
      ws        <= RUN;
      claimed   <= 1'b0;
      rd_bank   <= '0;
      ovf_pulse <= 1'b0;
      drop_cnt  <= '0;
      rd_zero   <= 1'b1;
    end else begin
      bs        <= bs_n;
      q         <= q_n;
      qc        <= qc_n;
      wr_bank   <= wr_bank_n;
      wr_ptr    <= wr_ptr_n;
      ws        <= ws_n;
      claimed   <= claimed_n;
      rd_bank   <= rd_bank_n;
      ovf_pulse <= ovf_n;
      if (ovf_n && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (rd_en) rd_zero <= !claimed;
    end
  end

  always_comb begin
    bs_n      = bs;
    q_n       = q;
    qc_n      = qc;
    wr_bank_n = wr_bank;
    wr_ptr_n  = wr_ptr;
    ws_n      = ws;
    claimed_n = claimed;
    rd_bank_n = rd_bank;
    ovf_n     = 1'b0;
    sel       = '0;
    if (frame_release && claimed) begin
      bs_n[rd_bank] = FREE;
      claimed_n     = 1'b0;
    end
    if (frame_take && qc != '0 && !claimed) begin
      rd_bank_n   = q[0];
      bs_n[q[0]]  = READING;
      claimed_n   = 1'b1;
      for (int i = 0; i < NUM_BANKS - 1; i++)
        q_n[i] = q_n[i+1];
      qc_n = qc_n - CW'(1);
    end
    unique case (ws)
      RUN: begin
        if (s_valid) begin
          wr_ptr_n = wr_ptr + AW'(1);
          if (wr_ptr == LAST) begin
            bs_n[wr_bank]  = FULL;
            q_n[BW'(qc_n)] = wr_bank;
            qc_n           = qc_n + CW'(1);
            sel            = first_free(bs_n, wr_bank);
            if (sel[BW]) begin
              wr_bank_n            = sel[BW-1:0];
              bs_n[sel[BW-1:0]]    = FILLING;
            end else if (OVERWRITE != 0) begin
              // victim is the oldest unread frame after any take
              wr_bank_n   = q_n[0];
              bs_n[q_n[0]] = FILLING;
              for (int i = 0; i < NUM_BANKS - 1; i++)
                q_n[i] = q_n[i+1];
              qc_n  = qc_n - CW'(1);
              ovf_n = 1'b1;
            end else begin
              ws_n = HOLD;
            end
          end
        end
      end
      HOLD: begin
        ovf_n = s_valid;
        sel   = first_free(bs_n, wr_bank);
        if (sel[BW]) begin
          ws_n              = RUN;
          wr_bank_n         = sel[BW-1:0];
          wr_ptr_n          = '0;
          bs_n[sel[BW-1:0]] = FILLING;
        end
      end
    endcase
  end

  always_comb begin
    frame_valid = (qc != '0) && !claimed;
    frame_bank  = (qc != '0) ? q[0] : '0;
    rd_data     = rd_zero ? '0 : ram_q;
  end

  frame_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_BANKS * FRAME_LEN),
    .AW     (BW + AW)
  ) u_ram (
    .clk_25 (clk_25),
    .we     ((ws == RUN) && s_valid),
    .waddr  ({wr_bank, wr_ptr}),
    .wdata  (s_data),
    .re     (rd_en && claimed),
    .raddr  ({rd_bank, rd_addr}),
    .rdata  (ram_q)
  );

endmodule
